mc_fifomem: RTL and testbench



---
 rtl/fifo_pkg.sv | 30 +++
 rtl/mc_fifo_chctl.sv | 99 +++++++++
 rtl/mc_fifomem.sv | 137 +++++++++++++
 tb/tb_mc_fifomem.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the multi-channel FIFO storage block.
//   ch_width()  - channel-index width, never narrower than one bit
//   FT_TRUE     - parameter value that selects first-word-fall-through reads
//   ch_stat_t   - per-channel pointer/status bundle exported by mc_fifo_chctl
package fifo_pkg;

   localparam string FT_TRUE   = "TRUE";

   // Pointers are carried zero-extended to a fixed width so one struct type
   // serves every ADDRSIZE; users take the low ADDRSIZE(+1) bits.
   localparam int    PTR_MAX_W = 17;

   typedef struct packed {
      logic [PTR_MAX_W-1:0] wptr;
      logic [PTR_MAX_W-1:0] rptr;
      logic                 full;
      logic                 empty;
   } ch_stat_t;

   function automatic int ch_width(input int num_ch);
      int w;
      w = $clog2(num_ch);
      if (w < 1) begin
         return 1;
      end else begin
         return w;
      end
   endfunction

endpackage

// File: rtl/mc_fifo_chctl.sv
// mc_fifo_chctl: pointer, occupancy, flag and sticky-error state of one channel.
//   wr_req/rd_req - requests already decoded for this channel
//   flush         - synchronous clear of both pointers, suppresses requests
//   err_clr       - clears sticky errors (a same-cycle new error wins)
//   wr_acc/rd_acc - request accepted this cycle (memory write / pop)
//   count_o, almost_full_o, ovf_err_o, udf_err_o, stat_o - channel status
module mc_fifo_chctl
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE = 4,
   parameter int AF_THR   = (1 << ADDRSIZE) - 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_req,
   input  logic                rd_req,
   input  logic                flush,
   input  logic                err_clr,
   output logic                wr_acc,
   output logic                rd_acc,
   output logic [ADDRSIZE:0]   count_o,
   output logic                almost_full_o,
   output logic                ovf_err_o,
   output logic                udf_err_o,
   output ch_stat_t            stat_o
);

   localparam int            PW      = ADDRSIZE + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(1 << ADDRSIZE);
   localparam logic [PW-1:0] AF_P    = PW'(AF_THR);

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic [PW-1:0] cnt_s;
   logic          full_s, empty_s;
   logic          ovf_set_s, udf_set_s;

   // The extra pointer bit distinguishes full from empty; count wraps mod 2^PW.
   assign cnt_s   = wptr_q - rptr_q;
   assign full_s  = (cnt_s == DEPTH_P);
   assign empty_s = (cnt_s == {PW{1'b0}});

   // Acceptance and errors use registered state only, so a same-cycle pop
   // never makes room for a write and a same-cycle write never feeds a pop.
   assign wr_acc    = wr_req & ~full_s  & ~flush;
   assign rd_acc    = rd_req & ~empty_s & ~flush;
   assign ovf_set_s = wr_req &  full_s  & ~flush;
   assign udf_set_s = rd_req &  empty_s & ~flush;

   // Next-state for pointers and sticky error flags.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush) begin
         wptr_d = {PW{1'b0}};
         rptr_d = {PW{1'b0}};
      end else begin
         if (wr_acc) begin
            wptr_d = wptr_q + PW'(1);
         end else begin
            wptr_d = wptr_q;
         end
         if (rd_acc) begin
            rptr_d = rptr_q + PW'(1);
         end else begin
            rptr_d = rptr_q;
         end
      end
      ovf_d = ovf_set_s | (ovf_q & ~err_clr);
      udf_d = udf_set_s | (udf_q & ~err_clr);
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= {PW{1'b0}};
         rptr_q <= {PW{1'b0}};
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
         udf_q  <= udf_d;
      end
   end

   assign count_o       = cnt_s;
   assign almost_full_o = (cnt_s >= AF_P);
   assign ovf_err_o     = ovf_q;
   assign udf_err_o     = udf_q;
   assign stat_o.wptr   = PTR_MAX_W'(wptr_q);
   assign stat_o.rptr   = PTR_MAX_W'(rptr_q);
   assign stat_o.full   = full_s;
   assign stat_o.empty  = empty_s;

endmodule

// File: rtl/mc_fifomem.sv
// mc_fifomem: NUM_CH logical FIFOs sharing one memory array; channel c owns
// words {c, 0..DEPTH-1}.
//   wr_en/wr_ch/wr_data - push;   rd_en/rd_ch - pop, result on rd_data/rd_valid
//   flush[c]            - synchronous per-channel clear
//   err_clr             - clears ovf_err/udf_err
//   full/empty/almost_full/count - per-channel status (count packed, ADDRSIZE+1 each)
// FALLTHROUGH == "TRUE": rd_data/rd_valid show the head of rd_ch combinationally.
// Otherwise rd_data/rd_valid are registered one cycle after an accepted pop.
module mc_fifomem
   import fifo_pkg::*;
#(
   parameter int    DATASIZE    = 8,
   parameter int    ADDRSIZE    = 4,
   parameter int    NUM_CH      = 4,
   parameter string FALLTHROUGH = "TRUE",
   parameter int    AF_THR      = (1 << ADDRSIZE) - 1,
   localparam int   CHW         = ch_width(NUM_CH)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wr_en,
   input  logic [CHW-1:0]                 wr_ch,
   input  logic [DATASIZE-1:0]            wr_data,
   input  logic                           rd_en,
   input  logic [CHW-1:0]                 rd_ch,
   output logic [DATASIZE-1:0]            rd_data,
   output logic                           rd_valid,
   input  logic [NUM_CH-1:0]              flush,
   input  logic                           err_clr,
   output logic [NUM_CH-1:0]              full,
   output logic [NUM_CH-1:0]              empty,
   output logic [NUM_CH-1:0]              almost_full,
   output logic [NUM_CH*(ADDRSIZE+1)-1:0] count,
   output logic [NUM_CH-1:0]              ovf_err,
   output logic [NUM_CH-1:0]              udf_err
);

   localparam int DEPTH = 1 << ADDRSIZE;
   localparam int PW    = ADDRSIZE + 1;
   localparam int AW    = CHW + ADDRSIZE;

   logic [DATASIZE-1:0] mem_q [NUM_CH*DEPTH];

   ch_stat_t            stat_s [NUM_CH];
   logic [NUM_CH-1:0]   wr_acc_s, rd_acc_s;
   logic                wr_ch_ok_s, rd_ch_ok_s;
   logic [CHW-1:0]      wr_idx_s, rd_idx_s;
   logic [AW-1:0]       wr_addr_s, rd_addr_s;
   logic [DATASIZE-1:0] head_data_s;

   // Out-of-range channel indices (non-power-of-2 NUM_CH) are ignored entirely.
   assign wr_ch_ok_s = (32'(wr_ch) < NUM_CH);
   assign rd_ch_ok_s = (32'(rd_ch) < NUM_CH);

   // Safe array indices: an out-of-range channel is steered to channel 0,
   // whose requests are already masked off by the decode below.
   always_comb begin
      if (wr_ch_ok_s) begin
         wr_idx_s = wr_ch;
      end else begin
         wr_idx_s = {CHW{1'b0}};
      end
      if (rd_ch_ok_s) begin
         rd_idx_s = rd_ch;
      end else begin
         rd_idx_s = {CHW{1'b0}};
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      mc_fifo_chctl #(
         .ADDRSIZE (ADDRSIZE),
         .AF_THR   (AF_THR)
      ) u_chctl (
         .clk           (clk),
         .rst_n         (rst_n),
         .wr_req        (wr_en & wr_ch_ok_s & (wr_ch == CHW'(c))),
         .rd_req        (rd_en & rd_ch_ok_s & (rd_ch == CHW'(c))),
         .flush         (flush[c]),
         .err_clr       (err_clr),
         .wr_acc        (wr_acc_s[c]),
         .rd_acc        (rd_acc_s[c]),
         .count_o       (count[c*PW +: PW]),
         .almost_full_o (almost_full[c]),
         .ovf_err_o     (ovf_err[c]),
         .udf_err_o     (udf_err[c]),
         .stat_o        (stat_s[c])
      );
      assign full[c]  = stat_s[c].full;
      assign empty[c] = stat_s[c].empty;
   end

   assign wr_addr_s   = {wr_idx_s, stat_s[wr_idx_s].wptr[ADDRSIZE-1:0]};
   assign rd_addr_s   = {rd_idx_s, stat_s[rd_idx_s].rptr[ADDRSIZE-1:0]};
   assign head_data_s = mem_q[rd_addr_s];

   // Storage array; deliberately not reset, contents survive rst_n and flush.
   always_ff @(posedge clk) begin
      if (|wr_acc_s) begin
         mem_q[wr_addr_s] <= wr_data;
      end
   end

   if (FALLTHROUGH == FT_TRUE) begin : g_ft
      assign rd_data  = head_data_s;
      assign rd_valid = rd_ch_ok_s & ~stat_s[rd_idx_s].empty;
   end else begin : g_reg
      logic [DATASIZE-1:0] rd_data_q, rd_data_d;
      logic                rd_valid_q, rd_valid_d;

      // Capture the head on an accepted pop; otherwise hold data, drop valid.
      always_comb begin
         if (|rd_acc_s) begin
            rd_data_d  = head_data_s;
            rd_valid_d = 1'b1;
         end else begin
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
         end
      end

      // Registered read port.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_data_q  <= {DATASIZE{1'b0}};
            rd_valid_q <= 1'b0;
         end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
         end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
   end

endmodule

// File: tb/tb_mc_fifomem.sv
// Directed bench: a fall-through and a registered-mode instance share all stimulus.
module tb_mc_fifomem;

   logic       clk, rst_n;
   logic       wr_en, wr_ch, rd_en, rd_ch, err_clr;
   logic [7:0] wr_data;
   logic [1:0] flush;

   logic [7:0] ft_rd_data, rg_rd_data;
   logic       ft_rd_valid, rg_rd_valid;
   logic [1:0] ft_full, ft_empty, ft_af, ft_ovf, ft_udf;
   logic [1:0] rg_full, rg_empty, rg_af, rg_ovf, rg_udf;
   logic [5:0] ft_count, rg_count;

   int checks   = 0;
   int failures = 0;

   mc_fifomem #(.DATASIZE(8), .ADDRSIZE(2), .NUM_CH(2), .FALLTHROUGH("TRUE"), .AF_THR(3)) dut_ft (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
      .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(ft_rd_data), .rd_valid(ft_rd_valid),
      .flush(flush), .err_clr(err_clr), .full(ft_full), .empty(ft_empty),
      .almost_full(ft_af), .count(ft_count), .ovf_err(ft_ovf), .udf_err(ft_udf));

   mc_fifomem #(.DATASIZE(8), .ADDRSIZE(2), .NUM_CH(2), .FALLTHROUGH("FALSE"), .AF_THR(3)) dut_rg (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
      .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rg_rd_data), .rd_valid(rg_rd_valid),
      .flush(flush), .err_clr(err_clr), .full(rg_full), .empty(rg_empty),
      .almost_full(rg_af), .count(rg_count), .ovf_err(rg_ovf), .udf_err(rg_udf));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic wch, input logic [7:0] wd,
                        input logic re, input logic rch, input logic [1:0] fl, input logic ec);
      wr_en = we; wr_ch = wch; wr_data = wd;
      rd_en = re; rd_ch = rch; flush = fl; err_clr = ec;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      #12;
      // Reset state
      chk("rst_count", ft_count, 6'd0);
      chk("rst_empty", ft_empty, 2'b11);
      chk("rst_full", ft_full, 2'b00);
      chk("rst_af", ft_af, 2'b00);
      chk("rst_ovf", ft_ovf, 2'b00);
      chk("rst_udf", ft_udf, 2'b00);
      chk("rst_ft_valid", ft_rd_valid, 1'b0);
      chk("rst_rg_valid", rg_rd_valid, 1'b0);
      chk("rst_rg_data", rg_rd_data, 8'h00);
      rst_n = 1'b1;
      tick();

      // 1: three writes to ch0, then three fall-through pops
      drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 2'b00, 1'b0); tick();
      drive(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 2'b00, 1'b0); tick();
      drive(1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 2'b00, 1'b0); tick();
      idle();
      chk("t1_count0", ft_count[2:0], 3'd3);
      chk("t1_af0", ft_af[0], 1'b1);
      chk("t1_empty1", ft_empty[1], 1'b1);
      chk("t1_empty0", ft_empty[0], 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0); #1;
      chk("t1_pop0_data", ft_rd_data, 8'h11);
      chk("t1_pop0_valid", ft_rd_valid, 1'b1);
      tick();
      chk("t1_rg_data0", rg_rd_data, 8'h11);
      chk("t1_rg_valid0", rg_rd_valid, 1'b1);
      chk("t1_pop1_data", ft_rd_data, 8'h22);
      chk("t1_pop1_valid", ft_rd_valid, 1'b1);
      tick();
      chk("t1_pop2_data", ft_rd_data, 8'h33);
      chk("t1_pop2_valid", ft_rd_valid, 1'b1);
      tick();
      idle(); #1;
      chk("t1_drained_empty0", ft_empty[0], 1'b1);
      chk("t1_drained_valid", ft_rd_valid, 1'b0);

      // 2: overfill ch1, sticky overflow, set-vs-clear priority
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 8'(8'hB1 + i), 1'b0, 1'b0, 2'b00, 1'b0);
         tick();
      end
      chk("t2_full1", ft_full[1], 1'b1);
      chk("t2_count1_full", ft_count[5:3], 3'd4);
      drive(1'b1, 1'b1, 8'hB5, 1'b0, 1'b0, 2'b00, 1'b0); tick();
      idle();
      chk("t2_ovf1", ft_ovf[1], 1'b1);
      chk("t2_count1_after_drop", ft_count[5:3], 3'd4);
      chk("t2_ovf0", ft_ovf[0], 1'b0);
      chk("t2_ch0_count", ft_count[2:0], 3'd0);
      chk("t2_ch0_empty", ft_empty[0], 1'b1);
      drive(1'b1, 1'b1, 8'hC0, 1'b0, 1'b0, 2'b00, 1'b1); tick();
      idle();
      chk("t2_set_beats_clr", ft_ovf[1], 1'b1);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1); tick();
      idle();
      chk("t2_ovf1_cleared", ft_ovf[1], 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0); #1;
      chk("t2_head1", ft_rd_data, 8'hB1);
      chk("t2_head1_valid", ft_rd_valid, 1'b1);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b10, 1'b0); tick();
      idle();
      chk("t2_flush1_count", ft_count[5:3], 3'd0);
      chk("t2_flush1_empty", ft_empty[1], 1'b1);

      // 3: pop of empty ch0 with same-cycle write
      drive(1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, 2'b00, 1'b0); tick();
      idle();
      chk("t3_udf0", ft_udf[0], 1'b1);
      chk("t3_count0", ft_count[2:0], 3'd1);
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0); #1;
      chk("t3_pop_data", ft_rd_data, 8'hAA);
      tick();
      idle();
      chk("t3_empty0", ft_empty[0], 1'b1);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1); tick();
      idle();
      chk("t3_udf0_cleared", ft_udf[0], 1'b0);

      // 4: streaming push/pop across the pointer wrap, 2 words resident
      drive(1'b1, 1'b0, 8'h40, 1'b0, 1'b0, 2'b00, 1'b0); tick();
      drive(1'b1, 1'b0, 8'h41, 1'b0, 1'b0, 2'b00, 1'b0); tick();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b0, 8'(8'h42 + i), 1'b1, 1'b0, 2'b00, 1'b0); #1;
         chk("t4_stream_data", ft_rd_data, 32'(8'h40 + i));
         tick();
         chk("t4_stream_count", ft_count[2:0], 3'd2);
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0); #1;
      chk("t4_drain0", ft_rd_data, 8'h4A);
      tick();
      chk("t4_drain1", ft_rd_data, 8'h4B);
      tick();
      idle();
      chk("t4_empty0", ft_empty[0], 1'b1);

      // 5: registered-mode latency
      drive(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 2'b00, 1'b0); tick();
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0); #1;
      chk("t5_rg_valid_pre", rg_rd_valid, 1'b0);
      tick();
      idle();
      chk("t5_rg_valid", rg_rd_valid, 1'b1);
      chk("t5_rg_data", rg_rd_data, 8'h5A);
      tick();
      chk("t5_rg_valid_idle", rg_rd_valid, 1'b0);
      chk("t5_rg_data_hold", rg_rd_data, 8'h5A);

      // 6: flush overrides write/read without error; async reset mid-burst
      drive(1'b1, 1'b0, 8'h61, 1'b0, 1'b0, 2'b00, 1'b0); tick();
      drive(1'b1, 1'b0, 8'h62, 1'b0, 1'b0, 2'b00, 1'b0); tick();
      drive(1'b1, 1'b0, 8'h63, 1'b0, 1'b0, 2'b00, 1'b0); tick();
      idle();
      chk("t6_count0_pre", ft_count[2:0], 3'd3);
      drive(1'b1, 1'b0, 8'h64, 1'b0, 1'b0, 2'b01, 1'b0); tick();
      idle();
      chk("t6_flush_count0", ft_count[2:0], 3'd0);
      chk("t6_flush_ovf0", ft_ovf[0], 1'b0);
      chk("t6_flush_empty0", ft_empty[0], 1'b1);
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 1'b0); tick();
      idle();
      chk("t6_flush_no_udf", ft_udf[0], 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0); tick();
      idle();
      chk("t6_udf1", ft_udf[1], 1'b1);
      drive(1'b1, 1'b1, 8'h70, 1'b0, 1'b0, 2'b00, 1'b0); tick();
      drive(1'b1, 1'b1, 8'h71, 1'b0, 1'b0, 2'b00, 1'b0); tick();
      chk("t6_burst_count1", ft_count[5:3], 3'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_arst_count", ft_count, 6'd0);
      chk("t6_arst_empty", ft_empty, 2'b11);
      chk("t6_arst_full", ft_full, 2'b00);
      chk("t6_arst_af", ft_af, 2'b00);
      chk("t6_arst_udf", ft_udf, 2'b00);
      chk("t6_arst_ovf", ft_ovf, 2'b00);
      chk("t6_arst_rg_data", rg_rd_data, 8'h00);
      chk("t6_arst_rg_count", rg_count, 6'd0);
      idle();
      #10;
      rst_n = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
